// File: rtl/lfsr_pkg.sv
// lfsr_pkg: shared XNOR LFSR step function, default tap table and width helpers.
package lfsr_pkg;
  localparam int MAX_W = 32;
  localparam logic [15:0] DEF_TAPS [3:16] = '{
    16'h0006, 16'h000C, 16'h0014, 16'h0030, 16'h0060, 16'h00B8, 16'h0110,
    16'h0240, 16'h0500, 16'h0829, 16'h100D, 16'h2015, 16'h6000, 16'hD008
  };
  function automatic logic [MAX_W-1:0] wmask(input int w);
    return {MAX_W{1'b1}} >> (MAX_W - w);
  endfunction
  function automatic logic [MAX_W-1:0] lfsr_step(input logic [MAX_W-1:0] q, input logic [MAX_W-1:0] mask, input int w);
    return ((q << 1) | MAX_W'(~^(q & mask))) & wmask(w);
  endfunction
  function automatic logic all_ones(input logic [MAX_W-1:0] q, input int w);
    return (q & wmask(w)) == wmask(w);
  endfunction
endpackage

// File: rtl/lfsr_gen_adv.sv
// lfsr_adv_comb: applies STEPS chained LFSR steps in one cycle and flags a return to start.
module lfsr_adv_comb
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAP_MASK = 8'hB8,
  parameter int STEPS = 1
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] start,
  output logic [WIDTH-1:0] nxt,
  output logic             hit
);
  logic [STEPS:0][WIDTH-1:0] s;
  assign s[0] = q;
  for (genvar g = 0; g < STEPS; g++) begin : g_step
    assign s[g+1] = WIDTH'(lfsr_step(MAX_W'(s[g]), MAX_W'(TAP_MASK), WIDTH));
  end
  assign nxt = s[STEPS];
  assign hit = nxt == start;
endmodule

// File: rtl/lfsr_gen.sv
// lfsr_gen: Fibonacci XNOR LFSR word generator with seed load, lock-up recovery,
// valid/ready output handshake and period measurement.
module lfsr_gen
  import lfsr_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] TAP_MASK = 8'hB8,
  parameter logic [WIDTH-1:0] SEED = 8'h5A,
  parameter int STEPS = 1,
  parameter int CNT_W = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             rnd_ready,
  output logic             rnd_valid,
  output logic [WIDTH-1:0] rnd_data,
  output logic             lockup,
  output logic             wrap,
  output logic [CNT_W-1:0] period_cnt
);
  if (WIDTH < 3 || STEPS < 1 || STEPS > WIDTH || TAP_MASK == '0 || SEED == '1) begin : g_bad_params
    $error("lfsr_gen: illegal parameter set");
  end
  logic [WIDTH-1:0] q, start, nxt, seed_ok;
  logic [CNT_W-1:0] cnt;
  logic hit, bad_seed, stuck, adv;
  lfsr_adv_comb #(.WIDTH(WIDTH), .TAP_MASK(TAP_MASK), .STEPS(STEPS)) u_adv (
    .q(q), .start(start), .nxt(nxt), .hit(hit)
  );
  // all-ones is a fixed point of the XNOR form, so it is never allowed to persist
  assign bad_seed = all_ones(MAX_W'(seed_in), WIDTH);
  assign seed_ok = bad_seed ? SEED : seed_in;
  assign stuck = !load && all_ones(MAX_W'(q), WIDTH);
  assign adv = en && !load && !stuck && (!rnd_valid || rnd_ready);
  assign rnd_data = q;
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= SEED;
      start <= SEED;
      rnd_valid <= 1'b0;
      lockup <= 1'b0;
      wrap <= 1'b0;
      cnt <= '0;
      period_cnt <= '0;
    end else begin
      lockup <= load ? bad_seed : stuck;
      wrap <= adv && hit;
      if (load) begin
        q <= seed_ok;
        start <= seed_ok;
        rnd_valid <= 1'b0;
        cnt <= '0;
      end else if (stuck) begin
        q <= SEED;
        rnd_valid <= 1'b0;
        cnt <= '0;
      end else if (adv) begin
        q <= nxt;
        rnd_valid <= 1'b1;
        cnt <= hit ? '0 : (&cnt ? cnt : cnt + 1'b1);
        if (hit) period_cnt <= cnt + 1'b1;
      end else if (rnd_ready) begin
        rnd_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_lfsr_gen.sv
// tb_lfsr_gen: scenario tasks plus a randomized run against an orbit-index reference model.
module tb_lfsr_gen;
  localparam logic [7:0] SEED = 8'h5A;
  logic clk = 1'b0, reset = 1'b1, en = 1'b0, load = 1'b0, rnd_ready = 1'b1;
  logic [7:0] seed_in = 8'h00;
  logic rnd_valid, lockup, wrap, rnd_valid3, lockup3, wrap3;
  logic [7:0] rnd_data, period_cnt, rnd_data3, period_cnt3;
  logic [7:0] orbit [255];
  int idx [256];
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  lfsr_gen dut (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in), .rnd_ready(rnd_ready),
    .rnd_valid(rnd_valid), .rnd_data(rnd_data), .lockup(lockup), .wrap(wrap), .period_cnt(period_cnt)
  );
  lfsr_gen #(.STEPS(3)) dut3 (
    .clk(clk), .reset(reset), .en(en), .load(load), .seed_in(seed_in), .rnd_ready(rnd_ready),
    .rnd_valid(rnd_valid3), .rnd_data(rnd_data3), .lockup(lockup3), .wrap(wrap3), .period_cnt(period_cnt3)
  );

  function automatic logic [7:0] step1(input logic [7:0] q);
    logic fb;
    fb = ($countones(q & 8'hB8) % 2) == 0;
    return {q[6:0], fb};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; en = 1'b0; load = 1'b0; rnd_ready = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; load = 1'b0; rnd_ready = 1'b1;
    tick(); tick();
    total += 5;
    if (rnd_data !== SEED) begin bad++; $display("FAIL reset_q: got %h want %h", rnd_data, SEED); end
    if (rnd_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", rnd_valid); end
    if (lockup !== 1'b0) begin bad++; $display("FAIL reset_lockup: got %b want 0", lockup); end
    if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
    if (period_cnt !== 8'd0) begin bad++; $display("FAIL reset_period: got %0d want 0", period_cnt); end
    total++;
    if (rnd_data3 !== SEED) begin bad++; $display("FAIL reset_q3: got %h want %h", rnd_data3, SEED); end
  endtask

  task automatic test_seq();
    logic [7:0] exp [2];
    exp[0] = 8'hB5; exp[1] = 8'h6A;
    reset = 1'b0; en = 1'b1; rnd_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      total += 2;
      if (rnd_data !== exp[k]) begin bad++; $display("FAIL seq%0d: got %h want %h", k, rnd_data, exp[k]); end
      if (rnd_valid !== 1'b1) begin bad++; $display("FAIL seq_valid%0d: got %b want 1", k, rnd_valid); end
    end
  endtask

  task automatic test_period();
    int nw = 0, wat = 0, nw3 = 0;
    bit ff_seen = 0;
    do_reset();
    en = 1'b1;
    for (int a = 1; a <= 255; a++) begin
      tick();
      if (wrap) begin nw++; wat = a; end
      if (wrap3) nw3++;
      if (rnd_data == 8'hFF) ff_seen = 1;
    end
    total += 7;
    if (nw != 1 || wat != 255) begin bad++; $display("FAIL period_wrap: got count %0d at %0d want 1 at 255", nw, wat); end
    if (rnd_data !== SEED) begin bad++; $display("FAIL period_q: got %h want %h", rnd_data, SEED); end
    if (period_cnt !== 8'd255) begin bad++; $display("FAIL period_cnt: got %0d want 255", period_cnt); end
    if (ff_seen) begin bad++; $display("FAIL period_ff: got all-ones state want never"); end
    if (nw3 != 3) begin bad++; $display("FAIL period_wrap3: got %0d want 3", nw3); end
    if (period_cnt3 !== 8'd85) begin bad++; $display("FAIL period_cnt3: got %0d want 85", period_cnt3); end
    tick();
    if (wrap !== 1'b0) begin bad++; $display("FAIL wrap_pulse: got %b want 0", wrap); end
  endtask

  task automatic test_backpressure();
    do_reset();
    en = 1'b1; rnd_ready = 1'b1;
    tick(); tick();
    rnd_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      total += 2;
      if (rnd_data !== orbit[2]) begin bad++; $display("FAIL bp_hold%0d: got %h want %h", c, rnd_data, orbit[2]); end
      if (rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_valid%0d: got %b want 1", c, rnd_valid); end
    end
    rnd_ready = 1'b1;
    tick();
    total += 2;
    if (rnd_data !== orbit[3]) begin bad++; $display("FAIL bp_resume: got %h want %h", rnd_data, orbit[3]); end
    if (rnd_valid !== 1'b1) begin bad++; $display("FAIL bp_resume_valid: got %b want 1", rnd_valid); end
    en = 1'b0;
    tick();
    total += 2;
    if (rnd_valid !== 1'b0) begin bad++; $display("FAIL consume_valid: got %b want 0", rnd_valid); end
    if (rnd_data !== orbit[3]) begin bad++; $display("FAIL consume_q: got %h want %h", rnd_data, orbit[3]); end
  endtask

  task automatic test_load();
    do_reset();
    en = 1'b1;
    tick(); tick();
    load = 1'b1; seed_in = 8'hFF;
    tick();
    total += 3;
    if (rnd_data !== SEED) begin bad++; $display("FAIL load_ff_q: got %h want %h", rnd_data, SEED); end
    if (lockup !== 1'b1) begin bad++; $display("FAIL load_ff_lockup: got %b want 1", lockup); end
    if (rnd_valid !== 1'b0) begin bad++; $display("FAIL load_ff_valid: got %b want 0", rnd_valid); end
    load = 1'b0; en = 1'b0;
    tick();
    total++;
    if (lockup !== 1'b0) begin bad++; $display("FAIL lockup_pulse: got %b want 0", lockup); end
    load = 1'b1; seed_in = 8'h01;
    tick();
    total += 3;
    if (rnd_data !== 8'h01) begin bad++; $display("FAIL load_q: got %h want 01", rnd_data); end
    if (lockup !== 1'b0) begin bad++; $display("FAIL load_lockup: got %b want 0", lockup); end
    if (rnd_valid !== 1'b0) begin bad++; $display("FAIL load_valid: got %b want 0", rnd_valid); end
    load = 1'b0; en = 1'b1;
    tick();
    total++;
    if (rnd_data !== orbit[(idx[1] + 1) % 255]) begin bad++; $display("FAIL load_adv: got %h want %h", rnd_data, orbit[(idx[1] + 1) % 255]); end
  endtask

  task automatic test_steps3();
    int wat = 0;
    logic [7:0] e;
    do_reset();
    en = 1'b1;
    tick();
    e = step1(step1(step1(SEED)));
    total += 2;
    if (rnd_data3 !== e) begin bad++; $display("FAIL steps3_first: got %h want %h", rnd_data3, e); end
    if (rnd_data3 !== orbit[3]) begin bad++; $display("FAIL steps3_orbit: got %h want %h", rnd_data3, orbit[3]); end
    for (int a = 2; a <= 90 && wat == 0; a++) begin
      tick();
      if (wrap3) wat = a;
    end
    total += 2;
    if (wat != 85) begin bad++; $display("FAIL steps3_wrap: got advance %0d want 85", wat); end
    if (period_cnt3 !== 8'd85) begin bad++; $display("FAIL steps3_period: got %0d want 85", period_cnt3); end
  endtask

  task automatic test_reset_mid();
    int wat = 0;
    do_reset();
    en = 1'b1;
    for (int a = 0; a < 100; a++) tick();
    reset = 1'b1; load = 1'b1; seed_in = 8'h33;
    tick();
    total += 4;
    if (rnd_data !== SEED) begin bad++; $display("FAIL rmid_q: got %h want %h", rnd_data, SEED); end
    if (rnd_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", rnd_valid); end
    if (wrap !== 1'b0 || lockup !== 1'b0) begin bad++; $display("FAIL rmid_pulse: got wrap %b lockup %b want 0 0", wrap, lockup); end
    if (period_cnt !== 8'd0) begin bad++; $display("FAIL rmid_period: got %0d want 0", period_cnt); end
    reset = 1'b0; load = 1'b0;
    for (int a = 1; a <= 260 && wat == 0; a++) begin
      tick();
      if (wrap) wat = a;
    end
    total++;
    if (wat != 255) begin bad++; $display("FAIL rmid_wrap: got advance %0d want 255", wat); end
  endtask

  task automatic test_random();
    int m_pos, m_spos, m_cnt, m_period;
    bit m_valid, m_lock, m_wrap;
    do_reset();
    m_pos = 0; m_spos = 0; m_cnt = 0; m_period = 0; m_valid = 0;
    for (int c = 0; c < 1500; c++) begin
      en = ($urandom_range(0, 3) != 0);
      rnd_ready = $urandom_range(0, 1) == 1;
      load = ($urandom_range(0, 199) == 0);
      seed_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      m_lock = 0; m_wrap = 0;
      if (load) begin
        m_lock = seed_in == 8'hFF;
        m_pos = m_lock ? 0 : idx[seed_in];
        m_spos = m_pos; m_valid = 0; m_cnt = 0;
      end else if (en && (!m_valid || rnd_ready)) begin
        m_pos = (m_pos + 1) % 255;
        m_valid = 1;
        if (m_pos == m_spos) begin m_wrap = 1; m_period = m_cnt + 1; m_cnt = 0; end
        else m_cnt = m_cnt + 1;
      end else if (rnd_ready) begin
        m_valid = 0;
      end
      tick();
      total += 5;
      if (rnd_data !== orbit[m_pos]) begin bad++; $display("FAIL rnd_q%0d: got %h want %h", c, rnd_data, orbit[m_pos]); end
      if (rnd_valid !== m_valid) begin bad++; $display("FAIL rnd_valid%0d: got %b want %b", c, rnd_valid, m_valid); end
      if (lockup !== m_lock) begin bad++; $display("FAIL rnd_lockup%0d: got %b want %b", c, lockup, m_lock); end
      if (wrap !== m_wrap) begin bad++; $display("FAIL rnd_wrap%0d: got %b want %b", c, wrap, m_wrap); end
      if (period_cnt !== 8'(m_period)) begin bad++; $display("FAIL rnd_period%0d: got %0d want %0d", c, period_cnt, m_period); end
    end
    load = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    for (int i = 0; i < 256; i++) idx[i] = -1;
    s = SEED;
    for (int i = 0; i < 255; i++) begin
      orbit[i] = s;
      idx[s] = i;
      s = step1(s);
    end
    test_reset();
    test_seq();
    test_period();
    test_backpressure();
    test_load();
    test_steps3();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
